// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Segment patterns are active-high and bit-ordered {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F; // a b c d e f
    localparam logic [6:0] SEG_1     = 7'h06; // b c
    localparam logic [6:0] SEG_2     = 7'h5B; // a b d e g
    localparam logic [6:0] SEG_3     = 7'h4F; // a b c d g
    localparam logic [6:0] SEG_4     = 7'h66; // b c f g
    localparam logic [6:0] SEG_5     = 7'h6D; // a c d f g
    localparam logic [6:0] SEG_6     = 7'h7D; // a c d e f g
    localparam logic [6:0] SEG_7     = 7'h07; // a b c
    localparam logic [6:0] SEG_8     = 7'h7F; // all segments
    localparam logic [6:0] SEG_9     = 7'h6F; // a b c d f g
    localparam logic [6:0] SEG_A     = 7'h77; // a b c e f g
    localparam logic [6:0] SEG_B     = 7'h7C; // c d e f g (lower-case b)
    localparam logic [6:0] SEG_C     = 7'h39; // a d e f
    localparam logic [6:0] SEG_D     = 7'h5E; // b c d e g (lower-case d)
    localparam logic [6:0] SEG_E     = 7'h79; // a d e f g
    localparam logic [6:0] SEG_F     = 7'h71; // a e f g
    localparam logic [6:0] SEG_BLANK = 7'h00; // nothing lit

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high segment pattern.
// Polarity and blanking are applied by the caller.
module seg7_hex_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    import seg7_scan_driver_pkg::*;

    // Full 0-F lookup.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit scan, hex decode,
// per-digit decimal point, optional leading-zero blanking, and a
// double-buffered value that only reaches the display at a frame wrap.
//
// Load protocol: 'load' is a single-cycle strobe with no back-pressure.
// The cycle it is high, value/dp_in are captured. Normally they go into
// the shadow register and 'pending' rises until the next frame wrap
// copies them into the display register. A strobe on the wrap cycle
// itself (frame_tick high) writes the display directly. While the
// display is dark, a pending shadow is committed on the next cycle.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_tick
);
    import seg7_scan_driver_pkg::*;

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    // Scan position
    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    // Display and shadow buffers
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0]   shad_val_q, shad_val_d;
    logic [DIGITS-1:0]     shad_dp_q, shad_dp_d;
    logic                  pending_q, pending_d;
    // Enable as seen last cycle: low means the outputs are already dark
    logic                  en_q;
    // Registered pin drivers
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  digit_end;
    logic                  frame_wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  all_zero;
    logic [DIGITS-1:0]     an_act;
    logic [6:0]            cur_pat;

    // Prescaler and digit index advance; both hold while disabled.
    always_comb begin
        pre_d      = pre_q;
        idx_d      = idx_q;
        digit_end  = enable && (pre_q == PRE_LAST);
        frame_wrap = digit_end && (idx_q == IDX_LAST);
        if (enable) begin
            if (digit_end) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // Shadow capture and display commit (wrap, wrap bypass, dark commit).
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
        pending_d  = pending_q;
        if (frame_wrap) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else if (pending_q) begin
                disp_val_d = shad_val_q;
                disp_dp_d  = shad_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shad_val_d = value;
            shad_dp_d  = dp_in;
            pending_d  = 1'b1;
        end else if (pending_q && !enable && !en_q) begin
            // Display is dark, so there is nothing to tear.
            disp_val_d = shad_val_q;
            disp_dp_d  = shad_dp_q;
            pending_d  = 1'b0;
        end
    end

    // Select the lit digit and decide whether it is a leading zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        all_zero  = 1'b1;
        an_act    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                an_act[i] = 1'b1;
                cur_blank = blank_lz && (i != 0) && all_zero;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_pat)
    );

    // Next pin values in active-high sense, then board polarity applied.
    always_comb begin
        an_d  = (enable ? an_act : '0) ^ {DIGITS{AN_INV}};
        seg_d = ((enable && !cur_blank) ? cur_pat : SEG_BLANK) ^ {7{SEG_INV}};
        dp_d  = (enable && cur_dp) ^ SEG_INV;
    end

    // All state, cleared asynchronously to the dark/idle condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            pending_q  <= 1'b0;
            en_q       <= 1'b0;
            an_q       <= {DIGITS{AN_INV}};
            seg_q      <= {7{SEG_INV}};
            dp_q       <= SEG_INV;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            shad_val_q <= shad_val_d;
            shad_dp_q  <= shad_dp_d;
            pending_q  <= pending_d;
            en_q       <= enable;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    // High during the cycle whose closing edge wraps the last digit to 0,
    // so a load seen together with it lands directly in the display.
    assign frame_tick = frame_wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle refresh,
// active-low segments and digit enables).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Expected {an, seg, dp} per digit of a frame
    logic [11:0] exp_q[$];

    // Hand-written active-low patterns for 0..F, bit order {g,f,e,d,c,b,a}
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    seg7_scan_driver #(
        .DIGITS         (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_an"}, an, 4'hF);
        check_eq({tag, "_seg"}, seg, 7'h7F);
        check_eq({tag, "_dp"}, dp, 1'b1);
    endtask

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv, input logic blz);
        logic [3:0]  nib;
        logic [15:0] upper;
        logic [6:0]  s;
        logic [3:0]  a;
        for (int d = 0; d < 4; d++) begin
            nib   = v[4*d +: 4];
            upper = v >> (4 * d);
            s     = (blz && d != 0 && upper == 16'h0) ? 7'h7F : seg_tbl[nib];
            a     = ~(4'b0001 << d);
            exp_q.push_back({a, s, ~dpv[d]});
        end
    endtask

    // Called at the first cycle digit 0 of a frame is visible.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] dpv, input logic blz);
        logic [11:0] e;
        push_frame(v, dpv, blz);
        for (int d = 0; d < 4; d++) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("scan_%04h_d%0d_c%0d", v, d, k), {an, seg, dp}, e);
                check_eq($sformatf("tick_%04h_d%0d_c%0d", v, d, k), frame_tick, (d == 3 && k == 2));
                step();
            end
        end
    endtask

    task automatic wait_tick(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq(tag, found, 1'b1);
    endtask

    task automatic commit_and_check(input string tag, input logic exp_pend,
                                    input logic [15:0] v, input logic [3:0] dpv, input logic blz);
        wait_tick({tag, "_tick"});
        check_eq({tag, "_pend_at_tick"}, pending, exp_pend);
        step();
        check_eq({tag, "_pend_after"}, pending, 1'b0);
        step();
        check_frame(v, dpv, blz);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;

        // Reset state before any clock edge
        #2;
        check_dark("rst_init");
        check_eq("rst_init_pend", pending, 1'b0);
        check_eq("rst_init_tick", frame_tick, 1'b0);

        // Basic load and full-frame scan
        step();
        reset  = 1'b0;
        enable = 1'b1;
        value  = 16'h12AF;
        dp_in  = 4'b0100;
        load   = 1'b1;
        step();
        load = 1'b0;
        check_eq("p_12af_set", pending, 1'b1);
        commit_and_check("f12af", 1'b1, 16'h12AF, 4'b0100, 1'b0);

        // Leading-zero blanking
        value    = 16'h0030;
        dp_in    = 4'b0000;
        blank_lz = 1'b1;
        load     = 1'b1;
        step();
        load = 1'b0;
        check_eq("p_0030_set", pending, 1'b1);
        commit_and_check("f0030", 1'b1, 16'h0030, 4'b0000, 1'b1);

        // Two loads inside one frame: last wins
        blank_lz = 1'b0;
        value    = 16'h1111;
        load     = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        value = 16'h2222;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_eq("p_2222_set", pending, 1'b1);
        commit_and_check("f2222", 1'b1, 16'h2222, 4'b0000, 1'b0);

        // Load on the wrap cycle bypasses the shadow
        wait_tick("beef_tick");
        check_eq("beef_pend_pre", pending, 1'b0);
        value = 16'hBEEF;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_eq("beef_pend_bypass", pending, 1'b0);
        step();
        check_frame(16'hBEEF, 4'b0000, 1'b0);

        // Disable with data pending, then load while dark, then resume
        value = 16'h5678;
        dp_in = 4'b1001;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_eq("dis_pend_set", pending, 1'b1);
        enable = 1'b0;
        step();
        check_dark("dis_dark");
        check_eq("dis_pend_hold", pending, 1'b1);
        check_eq("dis_tick", frame_tick, 1'b0);
        step();
        check_eq("dis_commit", pending, 1'b0);
        check_dark("dis_dark2");
        value = 16'h9C0D;
        dp_in = 4'b0010;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_eq("dis_load_pend", pending, 1'b1);
        check_dark("dis_dark3");
        step();
        check_eq("dis_load_commit", pending, 1'b0);
        repeat (2) step();
        check_dark("dis_dark4");
        enable = 1'b1;
        step();
        check_eq("resume_d0a", {an, seg, dp}, {4'b1110, 7'h21, 1'b1});
        step();
        check_eq("resume_d0b", {an, seg, dp}, {4'b1110, 7'h21, 1'b1});
        step();
        check_eq("resume_d1", {an, seg, dp}, {4'b1101, 7'h40, 1'b0});
        commit_and_check("f9c0d", 1'b0, 16'h9C0D, 4'b0010, 1'b0);

        // Asynchronous reset mid-scan with a pending shadow
        value = 16'h7777;
        dp_in = 4'b1111;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_eq("rst_mid_pend_set", pending, 1'b1);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_dark("rst_mid");
        check_eq("rst_mid_pend", pending, 1'b0);
        check_eq("rst_mid_tick", frame_tick, 1'b0);
        step();
        reset = 1'b0;
        commit_and_check("f_after_rst", 1'b0, 16'h0000, 4'b0000, 1'b0);

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed 7-segment display driver: full hex decode (0-F), time-multiplexed scan across DIGITS common-anode/cathode digits, per-digit decimal point, optional leading-zero blanking.
- Double-buffered value load, committed only at frame boundary (no tearing).
- Sits between lab datapaths (counters, ALU results) and the board's LED display; replaces per-digit discrete gate decoders.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 1000, clk cycles each digit stays lit (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low, 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = digit-enable outputs active-low, 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  1 = scan display; 0 = all digits dark.
- load  input  1  single-cycle strobe: capture value/dp_in into shadow register.
- value  input  4*DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant.
- dp_in  input  DIGITS  decimal point per digit.
- blank_lz  input  1  1 = blank leading zero digits.
- seg  output  7  {g,f,e,d,c,b,a}.
- dp  output  1  decimal point of lit digit.
- an  output  DIGITS  one-hot digit enable.
- pending  output  1  shadow loaded, not yet displayed.
- frame_tick  output  1  one-cycle pulse on digit DIGITS-1 -> 0 wrap.

Behaviour:
- Reset (async): prescaler=0, idx=0, display/shadow regs=0, pending=0, frame_tick=0; an, seg, dp all inactive (polarity per parameters).
- Prescaler counts 0..REFRESH_DIV-1 while enable=1; at terminal count it wraps to 0 and idx increments mod DIGITS. Wrap DIGITS-1 -> 0 pulses frame_tick for that cycle.
- Outputs are registered. an/seg/dp reflect current idx one cycle after idx changes; exactly one an bit active while enabled.
- Decode, active-high sense, inverted if SEG_ACTIVE_LOW:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg
- Leading-zero blanking (blank_lz=1): digit i>0 blanked (seg all inactive) if nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked. dp still follows dp_in bit of displayed digit. an stays active for blanked digits.
- Load:
  - load=1 writes shadow<=value, dp_in and sets pending=1.
  - At frame wrap with pending=1, display<=shadow and pending=0.
  - load while pending overwrites shadow; last load wins.
  - load on the wrap cycle bypasses: display<=value directly, pending stays 0.
- enable=0:
  - prescaler and idx frozen; an, seg, dp inactive next cycle; frame_tick=0.
  - Pending data commits on next cycle; load while disabled commits the following cycle.
  - On re-enable, scan resumes from frozen idx/prescaler.
- Reset mid-scan or mid-pending: all state cleared immediately; shadow contents lost.

Decomposition:
- Shared include/package: 16-entry segment pattern constants (SEG_0..SEG_F) and SEG_BLANK, all active-high.
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit pattern using those constants. Polarity inversion and blanking stay in the top level.

Test Plan (DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1):
- Reset asserted mid-scan -> an=4'b1111, seg=7'h7F, dp=1, pending=0 immediately, without waiting for clk.
- load value=16'h12AF, dp_in=4'b0100, blank_lz=0, enable=1:
  - frame commits; digits 0..3 show F=7'b0001110, A=7'b0001000, 2=7'b0100100, 1=7'b1111001.
  - an steps 1110,1101,1011,0111, each 4 cycles; dp=0 only on digit 2.
- value=16'h0030, blank_lz=1 -> digits 3,2 seg=7'h7F; digit 1 shows 3=7'b0110000; digit 0 shows 0=7'b1000000 (not blanked).
- load 16'h1111 mid-frame, then load 16'h2222 before wrap -> pending=1 until frame_tick; display shows 2222; 1111 never appears.
- load asserted on frame_tick cycle with 16'hBEEF -> pending stays 0; next frame shows b,E,E,F.
- enable=0 with pending=1:
  - an=4'b1111 next cycle; pending=0 one cycle later; idx frozen.
  - Re-enable: scan resumes at same digit with new value.
